// File: rtl/smult_arb_pkg.sv
// Shared definitions for the signed-multiplier arbiter.
//
// Contents:
//   MULT_LAT  - latency of the external multiplier (input reg + output reg)
//   NREQ_MAX  - largest supported requester count
//   tag_w()   - requester-ID width as a function of the requester count
//   TAG_W     - ID width used by the tag pipeline (sized for NREQ_MAX so
//               that every legal NREQ fits without per-instance structs)
//   tag_t     - one tag pipeline stage: {vld, id}
package smult_arb_pkg;

    localparam int MULT_LAT = 2;
    localparam int NREQ_MAX = 8;

    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    localparam int TAG_W = tag_w(NREQ_MAX);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/smult_arbiter_rr_grant.sv
// Combinational grant selection for smult_arbiter.
//
// Configuration macro: SMULT_ARB_ROUND_ROBIN_EN
//   defined   - round-robin: search starts at ptr and wraps modulo NREQ
//   undefined - fixed priority, lowest index wins (no ptr port)
//
// Ports:
//   req_valid  in   NREQ   pending requests
//   ptr        in   TAG_W  search start (round-robin build only)
//   grant      out  NREQ   one-hot grant, or zero
//   grant_any  out  1      some request was granted
//   grant_id   out  TAG_W  encoded index of the granted requester
module rr_grant import smult_arb_pkg::*; #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req_valid,
`ifdef SMULT_ARB_ROUND_ROBIN_EN
    input  logic [TAG_W-1:0] ptr,
`endif
    output logic [NREQ-1:0]  grant,
    output logic             grant_any,
    output logic [TAG_W-1:0] grant_id
);

    logic [NREQ-1:0]  rot;
    logic [TAG_W-1:0] offset;
`ifdef SMULT_ARB_ROUND_ROBIN_EN
    logic [2*NREQ-1:0] dbl;
    logic [TAG_W:0]    sum;
`endif

    always_comb begin
        rot       = '0;
        offset    = '0;
        grant_any = 1'b0;
        grant_id  = '0;
`ifdef SMULT_ARB_ROUND_ROBIN_EN
        // Rotating the doubled vector right by ptr puts the requester at
        // ptr in bit 0, so a plain lowest-bit search gives the wrapped order.
        dbl = {req_valid, req_valid} >> ptr;
        rot = dbl[NREQ-1:0];
        sum = '0;
`else
        rot = req_valid;
`endif
        // Walk downwards so the last hit (lowest offset) is the one kept.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_any = 1'b1;
                offset    = TAG_W'(k);
            end
        end
`ifdef SMULT_ARB_ROUND_ROBIN_EN
        // Undo the rotation: id = (ptr + offset) mod NREQ.
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (TAG_W+1)'(NREQ)) begin
            sum = sum - (TAG_W+1)'(NREQ);
        end
        grant_id = sum[TAG_W-1:0];
`else
        grant_id = offset;
`endif
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign grant[gi] = grant_any && (grant_id == TAG_W'(gi));
    end

endmodule

// File: rtl/smult_arbiter.sv
// Shares one external 2-cycle pipelined signed multiplier between NREQ
// requesters. One grant per cycle; the requester ID travels down a tag
// pipeline matching the multiplier latency and selects who receives the
// product as a one-cycle strobe.
//
// Configuration macro: SMULT_ARB_ROUND_ROBIN_EN (round-robin when defined,
// fixed lowest-index priority otherwise).
//
// Ports:
//   clk          in   1         clock, rising edge
//   reset        in   1         synchronous, active-high
//   req_valid    in   NREQ      request pending per requester
//   req_a/req_b  in   NREQ x N  operands per requester (signed)
//   req_ready    out  NREQ      grant, one-hot or zero
//   mult_a/b     out  N         operands to the multiplier (0 when idle)
//   mult_result  in   2N        product from the multiplier
//   resp_valid   out  NREQ      one-cycle response strobe
//   resp_result  out  2N        product passthrough
module smult_arbiter import smult_arb_pkg::*; #(
    parameter int N    = 8,
    parameter int NREQ = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0][N-1:0]    req_a,
    input  logic [NREQ-1:0][N-1:0]    req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [N-1:0]              mult_a,
    output logic [N-1:0]              mult_b,
    input  logic [2*N-1:0]            mult_result,
    output logic [NREQ-1:0]           resp_valid,
    output logic [2*N-1:0]            resp_result
);

    logic [NREQ-1:0]  raw_grant;
    logic             raw_any;
    logic             grant_any;
    logic [TAG_W-1:0] grant_id;
    tag_t             tag_d;
    tag_t             tag_q [MULT_LAT];

`ifdef SMULT_ARB_ROUND_ROBIN_EN
    logic [TAG_W-1:0] ptr_q;
    logic [TAG_W-1:0] ptr_d;
`endif

    rr_grant #(.NREQ(NREQ)) u_grant (
        .req_valid (req_valid),
`ifdef SMULT_ARB_ROUND_ROBIN_EN
        .ptr       (ptr_q),
`endif
        .grant     (raw_grant),
        .grant_any (raw_any),
        .grant_id  (grant_id)
    );

    // Nothing is granted while reset is held, so no operation can be
    // consumed during the reset cycle.
    assign req_ready = reset ? '0 : raw_grant;
    assign grant_any = raw_any & ~reset;

    always_comb begin
        mult_a = '0;
        mult_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                mult_a = req_a[i];
                mult_b = req_b[i];
            end
        end
    end

`ifdef SMULT_ARB_ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == TAG_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign tag_d = '{vld: grant_any, id: grant_id};

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q[0] <= '0;
        end else begin
            tag_q[0] <= tag_d;
        end
    end

    for (genvar gi = 1; gi < MULT_LAT; gi++) begin : g_tag
        always_ff @(posedge clk) begin
            if (reset) begin
                tag_q[gi] <= '0;
            end else begin
                tag_q[gi] <= tag_q[gi-1];
            end
        end
    end

    // The last stage lines up with the product leaving the multiplier.
    // Gating with reset hides the op that would otherwise land in the
    // reset cycle itself.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        assign resp_valid[gi] = ~reset & tag_q[MULT_LAT-1].vld &
                                (tag_q[MULT_LAT-1].id == TAG_W'(gi));
    end

    assign resp_result = mult_result;

endmodule

// File: tb/tb_smult_arbiter.sv
module tb_smult_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][N-1:0] req_a;
    logic [NREQ-1:0][N-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic [N-1:0]           mult_a;
    logic [N-1:0]           mult_b;
    logic [2*N-1:0]         mult_result;
    logic [NREQ-1:0]        resp_valid;
    logic [2*N-1:0]         resp_result;

    always #5 clk = ~clk;

    smult_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .resp_valid  (resp_valid),
        .resp_result (resp_result)
    );

    // External multiplier: input register then output register, no reset.
    logic signed [N-1:0] ma_q;
    logic signed [N-1:0] mb_q;
    always_ff @(posedge clk) begin
        ma_q        <= mult_a;
        mb_q        <= mult_b;
        mult_result <= ma_q * mb_q;
    end

    // Reference model: arbitration rule plus a queue of outstanding ops,
    // each due two cycles after its issue.
    typedef struct {
        int          due;
        int          id;
        logic [15:0] prod;
    } op_t;

    op_t             pend[$];
    int              nvec  = 0;
    int              nerr  = 0;
    int              cyc   = 0;
    int              m_ptr = 0;
    int              e_gid;
    logic [NREQ-1:0] e_ready;
    logic [NREQ-1:0] e_rv;
    logic [N-1:0]    e_ma;
    logic [N-1:0]    e_mb;
    logic [15:0]     e_res;
    logic [15:0]     g_res;

    task automatic model_eval();
        e_gid = -1;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
`ifdef SMULT_ARB_ROUND_ROBIN_EN
                i = (m_ptr + k) % NREQ;
`else
                i = k;
`endif
                if (e_gid < 0 && req_valid[i]) e_gid = i;
            end
        end
        e_ready = '0;
        e_ma    = '0;
        e_mb    = '0;
        if (e_gid >= 0) begin
            e_ready[e_gid] = 1'b1;
            e_ma = req_a[e_gid];
            e_mb = req_b[e_gid];
        end
        e_rv  = '0;
        e_res = '0;
        if (!reset && pend.size() > 0 && pend[0].due == cyc) begin
            e_rv[pend[0].id] = 1'b1;
            e_res = pend[0].prod;
        end
        g_res = (resp_valid != '0) ? resp_result : 16'h0;
    endtask

    task automatic drive(input logic rst, input logic [1:0] v,
                         input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1);
        reset     = rst;
        req_valid = v;
        req_a[0]  = a0;
        req_b[0]  = b0;
        req_a[1]  = a1;
        req_b[1]  = b1;
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            pend.delete();
            m_ptr = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
            if (e_gid >= 0) begin
                op_t o;
                int  p;
                p      = int'($signed(e_ma)) * int'($signed(e_mb));
                o.due  = cyc + 2;
                o.id   = e_gid;
                o.prod = 16'(p);
                pend.push_back(o);
                m_ptr = (e_gid + 1) % NREQ;
                $display("cyc %0d issue req%0d a=%0d b=%0d expect=%h", cyc, e_gid,
                         $signed(e_ma), $signed(e_mb), o.prod);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44);
            nvec++;
            if ({req_ready, mult_a, mult_b} !== 18'h0) begin
                nerr++;
                $display("FAIL reset_issue cyc=%0d got ready=%b a=%h b=%h want all 0",
                         cyc, req_ready, mult_a, mult_b);
            end
            nvec++;
            if (resp_valid !== 2'b00) begin
                nerr++;
                $display("FAIL reset_resp cyc=%0d got %b want 00", cyc, resp_valid);
            end
            advance();
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(1'b0, 2'b01, 8'hFD, 8'h05, 8'h00, 8'h00);
            else        drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            nvec++;
            if ({req_ready, mult_a, mult_b} !== {e_ready, e_ma, e_mb}) begin
                nerr++;
                $display("FAIL single_issue cyc=%0d got %b/%h/%h want %b/%h/%h",
                         cyc, req_ready, mult_a, mult_b, e_ready, e_ma, e_mb);
            end
            nvec++;
            if (c == 2) begin
                if ({resp_valid, resp_result} !== {2'b01, 16'hFFF1}) begin
                    nerr++;
                    $display("FAIL single_resp cyc=%0d got %b/%h want 01/fff1",
                             cyc, resp_valid, resp_result);
                end
            end else if (resp_valid !== 2'b00) begin
                nerr++;
                $display("FAIL single_quiet cyc=%0d got %b want 00", cyc, resp_valid);
            end
            advance();
        end
    endtask

    task automatic test_contention();
        logic [7:0] tab [6][4] = '{
            '{8'h80, 8'h80, 8'h7F, 8'h80},
            '{8'h7F, 8'h80, 8'h80, 8'h80},
            '{8'h03, 8'hFE, 8'h09, 8'h09},
            '{8'hFF, 8'hFF, 8'h00, 8'h55},
            '{8'h10, 8'h10, 8'hF0, 8'h10},
            '{8'h01, 8'h80, 8'h7F, 8'h7F}};
        drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        advance();
        for (int c = 0; c < 9; c++) begin
            if (c < 6) drive(1'b0, 2'b11, tab[c][0], tab[c][1], tab[c][2], tab[c][3]);
            else       drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            if (c < 6) begin
                logic [1:0] want;
`ifdef SMULT_ARB_ROUND_ROBIN_EN
                want = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
                want = 2'b01;
`endif
                nvec++;
                if (req_ready !== want) begin
                    nerr++;
                    $display("FAIL contend_grant cyc=%0d got %b want %b", cyc, req_ready, want);
                end
            end
            nvec++;
            if ({req_ready, mult_a, mult_b} !== {e_ready, e_ma, e_mb}) begin
                nerr++;
                $display("FAIL contend_issue cyc=%0d got %b/%h/%h want %b/%h/%h",
                         cyc, req_ready, mult_a, mult_b, e_ready, e_ma, e_mb);
            end
            nvec++;
            if ({resp_valid, g_res} !== {e_rv, e_res}) begin
                nerr++;
                $display("FAIL contend_resp cyc=%0d got %b/%h want %b/%h",
                         cyc, resp_valid, g_res, e_rv, e_res);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta [3] = '{8'd2, 8'd4, 8'd6};
        logic [7:0]  tb [3] = '{8'd3, 8'd5, 8'd7};
        logic [15:0] tp [3] = '{16'd6, 16'd20, 16'd42};
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(1'b0, 2'b10, 8'h00, 8'h00, ta[c], tb[c]);
            else       drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            nvec++;
            if ({req_ready, mult_a, mult_b} !== {e_ready, e_ma, e_mb}) begin
                nerr++;
                $display("FAIL b2b_issue cyc=%0d got %b/%h/%h want %b/%h/%h",
                         cyc, req_ready, mult_a, mult_b, e_ready, e_ma, e_mb);
            end
            if (c >= 2 && c <= 4) begin
                nvec++;
                if ({resp_valid, resp_result} !== {2'b10, tp[c-2]}) begin
                    nerr++;
                    $display("FAIL b2b_resp cyc=%0d got %b/%0d want 10/%0d",
                             cyc, resp_valid, resp_result, tp[c-2]);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b0, 2'b01, 8'h05, 8'h05, 8'h00, 8'h00);
        advance();
        drive(1'b0, 2'b10, 8'h00, 8'h00, 8'h07, 8'h07);
        advance();
        drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        nvec++;
        if (resp_valid !== 2'b00) begin
            nerr++;
            $display("FAIL inflight_rstcyc cyc=%0d got %b want 00", cyc, resp_valid);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
            nvec++;
            if (resp_valid !== 2'b00) begin
                nerr++;
                $display("FAIL inflight_quiet cyc=%0d got %b want 00", cyc, resp_valid);
            end
            advance();
        end
        drive(1'b0, 2'b11, 8'h02, 8'h02, 8'h03, 8'h03);
        nvec++;
        if (req_ready !== 2'b01) begin
            nerr++;
            $display("FAIL inflight_regrant cyc=%0d got %b want 01", cyc, req_ready);
        end
        advance();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 7; c++) begin
            if (c < 5) drive(1'b0, 2'b00, 8'h5A, 8'hA5, 8'h3C, 8'hC3);
            else       drive(1'b0, 2'b11, 8'h09, 8'hF7, 8'h0B, 8'h0B);
            if (c >= 2 && c < 5) begin
                nvec++;
                if ({req_ready, mult_a, mult_b, resp_valid} !== 20'h0) begin
                    nerr++;
                    $display("FAIL idle_zero cyc=%0d got %b/%h/%h/%b want all 0",
                             cyc, req_ready, mult_a, mult_b, resp_valid);
                end
            end
            nvec++;
            if ({req_ready, mult_a, mult_b} !== {e_ready, e_ma, e_mb}) begin
                nerr++;
                $display("FAIL idle_issue cyc=%0d got %b/%h/%h want %b/%h/%h",
                         cyc, req_ready, mult_a, mult_b, e_ready, e_ma, e_mb);
            end
            nvec++;
            if ({resp_valid, g_res} !== {e_rv, e_res}) begin
                nerr++;
                $display("FAIL idle_resp cyc=%0d got %b/%h want %b/%h",
                         cyc, resp_valid, g_res, e_rv, e_res);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, 2'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            nvec++;
            if ({req_ready, mult_a, mult_b} !== {e_ready, e_ma, e_mb}) begin
                nerr++;
                $display("FAIL random_issue cyc=%0d got %b/%h/%h want %b/%h/%h",
                         cyc, req_ready, mult_a, mult_b, e_ready, e_ma, e_mb);
            end
            nvec++;
            if ({resp_valid, g_res} !== {e_rv, e_res}) begin
                nerr++;
                $display("FAIL random_resp cyc=%0d got %b/%h want %b/%h",
                         cyc, resp_valid, g_res, e_rv, e_res);
            end
            advance();
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_reset_inflight();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/smult_arbiter.md
# smult_arbiter

Shares one pipelined signed multiplier between `NREQ` requesters (e.g. pico-MIPS execute stage and the address/affine unit). Each cycle it grants at most one valid request, drives its operands to the multiplier, and carries the requester ID through a tag pipeline that matches the multiplier latency. When the product emerges, it returns the product to the originating requester with a one-cycle response strobe. Full throughput: one issue per cycle, no bubbles.

## Interface
- `N`, default 8: operand width. Operands are signed two's complement.
- `NREQ`, default 2: number of requesters, 2..8.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_a`, `req_b`  in  NREQ×N (packed `[NREQ-1:0][N-1:0]`): operands per requester.
- `req_ready`  out  NREQ: grant, at most one bit high (one-hot or zero).
- `mult_a`, `mult_b`  out  N: operands to the external synchronized multiplier.
- `mult_result`  in  2N: product from the multiplier, 2-cycle latency.
- `resp_valid`  out  NREQ: one-cycle strobe to the originating requester.
- `resp_result`  out  2N: shared result bus, meaningful only while any `resp_valid` is high.

## Operation
- Grant logic:
  - Grant is combinational from `req_valid` and the priority pointer.
  - A request is consumed when `req_valid[i] & req_ready[i]` is high at a rising edge.
  - `req_ready[i]` is never high unless `req_valid[i]` is high. Requesters must not make `req_valid` depend on `req_ready`.
- Operand mux:
  - `mult_a`/`mult_b` = granted requester's operands.
  - With no grant, both are 0.
- Tag pipeline:
  - Two registered stages, each holding {`vld`, `id`}.
  - Stage 1 captures {grant_any, grant_id}; stage 2 captures stage 1.
- Response:
  - `resp_valid` = onehot(stage2.id) gated by stage2.vld.
  - `resp_result` = `mult_result` passthrough.
- No response backpressure. A requester must sink the response in the strobe cycle.
- Requesters may issue back-to-back. Multiple operations from one requester may be in flight and return in issue order.
- Reset:
  - Clears both tag stages and the priority pointer to 0.
  - Operations in flight at reset never produce `resp_valid`. Their products are discarded even though the multiplier (no reset) still computes them.
  - During reset, `req_ready` = 0 and `mult_a`/`mult_b` = 0.
- Reset values: `req_ready` 0, `resp_valid` 0, `mult_a`/`mult_b` 0. `resp_result` follows `mult_result` and is don't-care.

## Timing
- Issue in cycle t (handshake at edge ending t) → `resp_valid` and correct `resp_result` in cycle t+2.
- Latency is fixed at 2 cycles: one multiplier input register plus one output register.
- Throughput: 1 op/cycle sustained across any mix of requesters.
- Pointer update:
  - On a grant to i, the pointer becomes (i+1) mod NREQ at the edge.
  - With no grant, the pointer is unchanged.
  - A simultaneous request from every requester is resolved purely by the pointer.
- A response and a new issue in the same cycle, including for the same requester, are independent.

## Configuration
- `SMULT_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin grant. Search starts at the pointer and wraps modulo NREQ.
  - Guarantees a persistent requester is granted within NREQ cycles.
- `SMULT_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, lowest index wins.
  - Pointer register is not implemented.
  - Starvation of high indices is permitted.

## Structure
- Package `smult_arb_pkg`:
  - `MULT_LAT = 2`.
  - `TAG_W = (NREQ>1) ? $clog2(NREQ) : 1`, provided as a function of NREQ.
  - Packed struct `tag_t {logic vld; logic [TAG_W-1:0] id;}`.
- Sub-module `rr_grant`:
  - Pure combinational one-hot grant from (`req_valid`, pointer) plus encoded grant ID.
  - Fixed-priority variant selected under the macro.
- Top level holds the pointer, the tag pipeline and the operand mux.
- The multiplier is instantiated by the parent, beside this block.

## Test plan
- N=8, NREQ=2, only req 0 issues a=−3 (0xFD), b=5 at cycle 0 → `resp_valid`=2'b01 in cycle 2, `resp_result`=0xFFF1 (−15); no other strobes.
- Both requesters valid continuously for 6 cycles, round-robin build → grants alternate 0,1,0,1,0,1. Responses alternate with 2-cycle offset, products correct (e.g. −128×−128=0x4000, 127×−128=0xC080).
- Same stimulus without `SMULT_ARB_ROUND_ROBIN_EN` → req 0 granted every cycle, `req_ready[1]` never high.
- Req 1 issues back-to-back 2×3, 4×5, 6×7 → `resp_valid[1]` high three consecutive cycles with 6, 20, 42 in order.
- Assert `reset` for one cycle with two ops in flight → no `resp_valid` in the following 3 cycles. Pointer is 0; the next simultaneous request grants req 0.
- Idle for 5 cycles (`req_valid`=0) → `req_ready`=0, `mult_a`=`mult_b`=0, `resp_valid`=0 throughout; pointer unchanged.
